// File: rtl/clk_div_multi_pkg.sv
// Shared constants, channel mode encoding and divisor clamp for the clock divider.
// Pure definitions: no latency or backpressure of its own.
package clk_div_multi_pkg;

   localparam int MIN_DIV   = 2;
   localparam int DEF_CNT_W = 16;
   localparam int DEF_DIV   = 10;
   localparam int CLAMP_W   = 32;

   typedef enum logic {
      MODE_RUN  = 1'b0,
      MODE_STOP = 1'b1
   } ch_mode_e;

   // A divisor below MIN_DIV cannot form a low and a high phase.
   function automatic logic [CLAMP_W-1:0] clamp_div(input logic [CLAMP_W-1:0] d);
      return (d < CLAMP_W'(MIN_DIV)) ? CLAMP_W'(MIN_DIV) : d;
   endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Control/status bundle of the multi-channel divider; the DUT takes the slave side.
// No latency of its own; no backpressure (plain strobes and levels).
interface clk_div_multi_if
   import clk_div_multi_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = DEF_CNT_W
);

   logic [NUM_CH-1:0]       run;
   logic [NUM_CH-1:0]       div_wr;
   logic [CNT_W-1:0]        div_data;
   logic [NUM_CH-1:0]       clk_out;
   logic [NUM_CH-1:0]       tick;
   logic [NUM_CH-1:0]       busy;
   logic [NUM_CH*CNT_W-1:0] div_cur;

   modport master (
      output run, div_wr, div_data,
      input  clk_out, tick, busy, div_cur
   );

   modport slave (
      input  run, div_wr, div_data,
      output clk_out, tick, busy, div_cur
   );

endinterface

// File: rtl/clk_div_multi_ch.sv
// One divider channel: counter, active/pending divisor, stop control, registered clk_out/tick.
// Latency: outputs registered from next-count; no backpressure, a write while busy overwrites pending.
module clk_div_multi_ch
   import clk_div_multi_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int DEFAULT_DIV = DEF_DIV
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             div_wr,
   input  logic [CNT_W-1:0] div_data,
   output logic             clk_out,
   output logic             tick,
   output logic             busy,
   output logic [CNT_W-1:0] div_cur
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] pend_q, pend_d;
   logic             busy_q, busy_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   ch_mode_e         mode_q, mode_d;

   logic wrap;
   logic apply;
   logic advance;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q     <= '0;
         div_q     <= CNT_W'(DEFAULT_DIV);
         pend_q    <= CNT_W'(DEFAULT_DIV);
         busy_q    <= 1'b0;
         clk_out_q <= 1'b0;
         tick_q    <= 1'b0;
         mode_q    <= MODE_RUN;
      end else begin
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         pend_q    <= pend_d;
         busy_q    <= busy_d;
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
         mode_q    <= mode_d;
      end
   end

   always_comb begin
      wrap    = (cnt_q == div_q - CNT_W'(1));
      apply   = busy_q && (wrap || (mode_q == MODE_STOP));
      // A period already under way always runs to its end, even with run low.
      advance = run || (cnt_q != '0);

      cnt_d = cnt_q;
      if (advance) begin
         cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
      end

      div_d  = apply ? pend_q : div_q;
      pend_d = pend_q;
      busy_d = busy_q;
      if (div_wr) begin
         pend_d = CNT_W'(clamp_div(CLAMP_W'(div_data)));
         busy_d = 1'b1;
      end else if (apply) begin
         busy_d = 1'b0;
      end

      mode_d = ((cnt_d == '0) && !run) ? MODE_STOP : MODE_RUN;

      // Duty is judged against the divisor that owns the next count value.
      clk_out_d = (cnt_d >= (div_d >> 1));
      tick_d    = clk_out_d && !clk_out_q;
   end

   assign clk_out = clk_out_q;
   assign tick    = tick_q;
   assign busy    = busy_q;
   assign div_cur = div_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider; one independent channel per bus lane.
// Latency: clk_out/tick registered, divisor changes land on the period boundary; no backpressure.
module clk_div_multi
   import clk_div_multi_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int DEFAULT_DIV = DEF_DIV
) (
   input  logic          clk,
   input  logic          reset,
   clk_div_multi_if.slave bus
);

   logic [NUM_CH-1:0]       clk_out_w;
   logic [NUM_CH-1:0]       tick_w;
   logic [NUM_CH-1:0]       busy_w;
   logic [NUM_CH*CNT_W-1:0] div_cur_w;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clk_div_multi_ch #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk      (clk),
         .reset    (reset),
         .run      (bus.run[i]),
         .div_wr   (bus.div_wr[i]),
         .div_data (bus.div_data),
         .clk_out  (clk_out_w[i]),
         .tick     (tick_w[i]),
         .busy     (busy_w[i]),
         .div_cur  (div_cur_w[i*CNT_W +: CNT_W])
      );
   end

   assign bus.clk_out = clk_out_w;
   assign bus.tick    = tick_w;
   assign bus.busy    = busy_w;
   assign bus.div_cur = div_cur_w;

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed scenarios with arithmetic expectations plus a
// randomized run against a period-level reference model.
module tb_clk_div_multi;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   edge_n = 0;

   clk_div_multi_if #(.NUM_CH(2), .CNT_W(16)) bus ();

   clk_div_multi #(.NUM_CH(2), .CNT_W(16), .DEFAULT_DIV(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [15:0] cur0, cur1;
   assign cur0 = bus.div_cur[15:0];
   assign cur1 = bus.div_cur[31:16];

   task automatic step();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic do_reset(input logic [1:0] run_v);
      reset        = 1'b1;
      bus.run      = 2'b00;
      bus.div_wr   = 2'b00;
      bus.div_data = 16'd0;
      @(posedge clk);
      #1;
      bus.run = run_v;
      reset   = 1'b0;
      edge_n  = 0;
   endtask

   task automatic wait_idle(input int ch, output bit ok);
      int n = 0;
      while (bus.busy[ch] === 1'b1 && n < 40) begin
         step();
         n++;
      end
      ok = (bus.busy[ch] === 1'b0);
   endtask

   task automatic test_reset();
      bus.run      = 2'b00;
      bus.div_wr   = 2'b00;
      bus.div_data = 16'd0;
      #1 reset = 1'b1;
      #2;
      checks++;
      if (bus.clk_out !== 2'b00) begin errors++; $display("FAIL reset_clk_out got=%b want=00", bus.clk_out); end
      checks++;
      if (bus.tick !== 2'b00) begin errors++; $display("FAIL reset_tick got=%b want=00", bus.tick); end
      checks++;
      if (bus.busy !== 2'b00) begin errors++; $display("FAIL reset_busy got=%b want=00", bus.busy); end
      checks++;
      if (bus.div_cur !== {16'd10, 16'd10}) begin errors++; $display("FAIL reset_div_cur got=%h want=000a000a", bus.div_cur); end
   endtask

   task automatic test_default_period();
      logic ec, et;
      do_reset(2'b11);
      for (int e = 1; e <= 26; e++) begin
         step();
         ec = ((e % 10) >= 5);
         et = ((e % 10) == 5);
         checks++;
         if (bus.clk_out !== {2{ec}} || bus.tick !== {2{et}}) begin
            errors++;
            $display("FAIL default_period edge=%0d clk_out=%b want=%b tick=%b want=%b", e, bus.clk_out, {2{ec}}, bus.tick, {2{et}});
         end
      end
   endtask

   task automatic test_div_change();
      logic ec, eb;
      logic [15:0] ed;
      do_reset(2'b01);
      repeat (3) step();
      bus.div_data = 16'd7;
      bus.div_wr   = 2'b01;
      step();
      bus.div_wr   = 2'b00;
      for (int e = 4; e <= 24; e++) begin
         eb = (e < 10);
         ed = (e < 10) ? 16'd10 : 16'd7;
         ec = (e < 10) ? (e >= 5) : (((e - 10) % 7) >= 3);
         checks++;
         if (bus.busy[0] !== eb || cur0 !== ed || bus.clk_out[0] !== ec) begin
            errors++;
            $display("FAIL div_change edge=%0d busy=%b want=%b div=%0d want=%0d clk=%b want=%b", e, bus.busy[0], eb, cur0, ed, bus.clk_out[0], ec);
         end
         step();
      end
   endtask

   task automatic test_clamp();
      bit ok;
      logic ex;
      do_reset(2'b01);
      bus.div_data = 16'd0;
      bus.div_wr   = 2'b01;
      step();
      bus.div_wr   = 2'b00;
      wait_idle(0, ok);
      checks++;
      if (!ok || cur0 !== 16'd2) begin errors++; $display("FAIL clamp_zero idle=%0d div=%0d want=2", ok, cur0); end
      for (int k = 1; k <= 8; k++) begin
         step();
         ex = k[0];
         checks++;
         if (bus.clk_out[0] !== ex || bus.tick[0] !== ex) begin
            errors++;
            $display("FAIL clamp_toggle k=%0d clk=%b tick=%b want=%b", k, bus.clk_out[0], bus.tick[0], ex);
         end
      end
      bus.div_data = 16'd5;
      bus.div_wr   = 2'b01;
      step();
      bus.div_wr   = 2'b00;
      wait_idle(0, ok);
      checks++;
      if (!ok || cur0 !== 16'd5) begin errors++; $display("FAIL clamp_five idle=%0d div=%0d want=5", ok, cur0); end
      bus.div_data = 16'd1;
      bus.div_wr   = 2'b01;
      step();
      bus.div_wr   = 2'b00;
      wait_idle(0, ok);
      checks++;
      if (!ok || cur0 !== 16'd2) begin errors++; $display("FAIL clamp_one idle=%0d div=%0d want=2", ok, cur0); end
   endtask

   task automatic test_stop_start();
      logic ec, et, e1;
      do_reset(2'b11);
      repeat (7) step();
      bus.run[0] = 1'b0;
      for (int e = 8; e <= 20; e++) begin
         step();
         ec = (e < 10);
         e1 = ((e % 10) >= 5);
         checks++;
         if (bus.clk_out[0] !== ec || bus.tick[0] !== 1'b0 || bus.clk_out[1] !== e1) begin
            errors++;
            $display("FAIL stop edge=%0d clk=%b want=%b tick=%b want=0 ch1=%b want=%b", e, bus.clk_out[0], ec, bus.tick[0], bus.clk_out[1], e1);
         end
      end
      bus.run[0] = 1'b1;
      for (int e = 21; e <= 26; e++) begin
         step();
         ec = ((e - 20) >= 5);
         et = ((e - 20) == 5);
         checks++;
         if (bus.clk_out[0] !== ec || bus.tick[0] !== et) begin
            errors++;
            $display("FAIL start edge=%0d clk=%b want=%b tick=%b want=%b", e, bus.clk_out[0], ec, bus.tick[0], et);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic c0, c1, b0;
      logic [15:0] d0;
      do_reset(2'b11);
      bus.div_data = 16'd4;
      bus.div_wr   = 2'b01;
      step();
      bus.div_data = 16'd6;
      bus.div_wr   = 2'b10;
      step();
      bus.div_wr   = 2'b00;
      while (edge_n < 13) step();
      // ch0 sits at the last count of a 4-cycle period here: write on its wrap cycle.
      bus.div_data = 16'd8;
      bus.div_wr   = 2'b01;
      step();
      bus.div_wr   = 2'b00;
      for (int e = 14; e <= 40; e++) begin
         c0 = (e < 18) ? (((e - 10) % 4) >= 2) : (((e - 18) % 8) >= 4);
         b0 = (e < 18);
         d0 = (e < 18) ? 16'd4 : 16'd8;
         c1 = (((e - 10) % 6) >= 3);
         checks++;
         if (bus.clk_out !== {c1, c0} || bus.busy !== {1'b0, b0} || cur0 !== d0 || cur1 !== 16'd6) begin
            errors++;
            $display("FAIL indep edge=%0d clk=%b want=%b busy=%b want=%b div0=%0d want=%0d div1=%0d want=6", e, bus.clk_out, {c1, c0}, bus.busy, {1'b0, b0}, cur0, d0, cur1);
         end
         step();
      end
   endtask

   task automatic test_async_reset();
      do_reset(2'b11);
      repeat (4) step();
      bus.div_data = 16'd3;
      bus.div_wr   = 2'b11;
      step();
      bus.div_wr   = 2'b00;
      checks++;
      if (bus.clk_out !== 2'b11 || bus.tick !== 2'b11 || bus.busy !== 2'b11) begin
         errors++;
         $display("FAIL async_pre clk=%b tick=%b busy=%b want=11", bus.clk_out, bus.tick, bus.busy);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (bus.clk_out !== 2'b00 || bus.tick !== 2'b00 || bus.busy !== 2'b00 || bus.div_cur !== {16'd10, 16'd10}) begin
         errors++;
         $display("FAIL async_reset clk=%b tick=%b busy=%b div=%h want=0/0/0/000a000a", bus.clk_out, bus.tick, bus.busy, bus.div_cur);
      end
   endtask

   // Reference: position within the period, active and queued divisor, stop flag.
   int m_pos [2];
   int m_div [2];
   int m_pend[2];
   bit m_busy[2];
   bit m_halt[2];
   bit m_clk [2];
   bit m_tick[2];

   task automatic test_random();
      logic [1:0]  r, w, ec, et, eb;
      logic [15:0] d;
      int          old_div;
      bit          prev;
      do_reset(2'b11);
      for (int c = 0; c < 2; c++) begin
         m_pos[c] = 0; m_div[c] = 10; m_pend[c] = 10;
         m_busy[c] = 0; m_halt[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
      end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int c = 0; c < 2; c++) begin
            if ($urandom_range(0, 39) == 0) bus.run[c] = ~bus.run[c];
            bus.div_wr[c] = ($urandom_range(0, 15) == 0);
         end
         bus.div_data = 16'($urandom_range(0, 13));
         r = bus.run;
         w = bus.div_wr;
         d = bus.div_data;
         step();
         for (int c = 0; c < 2; c++) begin
            old_div = m_div[c];
            if (m_busy[c] && (m_pos[c] == old_div - 1 || m_halt[c])) begin
               m_div[c]  = m_pend[c];
               m_busy[c] = 0;
            end
            if (r[c] || m_pos[c] != 0) m_pos[c] = (m_pos[c] + 1) % old_div;
            m_halt[c] = (m_pos[c] == 0) && !r[c];
            if (w[c]) begin
               m_pend[c] = (d < 16'd2) ? 2 : int'(d);
               m_busy[c] = 1;
            end
            prev      = m_clk[c];
            m_clk[c]  = (m_pos[c] >= m_div[c] / 2);
            m_tick[c] = m_clk[c] && !prev;
            ec[c] = m_clk[c];
            et[c] = m_tick[c];
            eb[c] = m_busy[c];
         end
         checks++;
         if (bus.clk_out !== ec || bus.tick !== et || bus.busy !== eb ||
             cur0 !== 16'(m_div[0]) || cur1 !== 16'(m_div[1])) begin
            errors++;
            $display("FAIL random cyc=%0d clk=%b want=%b tick=%b want=%b busy=%b want=%b div0=%0d want=%0d div1=%0d want=%0d",
                     cyc, bus.clk_out, ec, bus.tick, et, bus.busy, eb, cur0, m_div[0], cur1, m_div[1]);
         end
      end
   endtask

   initial begin
      bus.run      = 2'b00;
      bus.div_wr   = 2'b00;
      bus.div_data = 16'd0;
      test_reset();
      test_default_period();
      test_div_change();
      test_clamp();
      test_stop_start();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
